// File: rtl/branch_pkg.sv
// Shared types and constants for the sequential RV32I branch comparator.
package branch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmp,
    StDone
  } brState;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // funct3 010/011 have no branch meaning.
  function automatic logic isIllegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

  // Branch decision from the equality / less-than flags.
  function automatic logic takenOf(input logic [2:0] f3, input logic eq, input logic lt);
    logic res;
    res = 1'b0;
    case (f3)
      BEQ:        res = eq;
      BNE:        res = !eq;
      BLT, BLTU:  res = lt;
      BGE, BGEU:  res = !lt;
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/chunk_comp.sv
// Combinational unsigned compare of one operand slice.
module chunk_comp #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/branch_comp_seq.sv
// Sequential branch comparator: walks the operands CHUNK bits per cycle, MSB slice first.
// Optional macro BRCOMP_EARLY_EXIT_EN finishes on the first differing slice; the default
// build always spends NCHUNK cycles in compare. Results are identical in both builds.
module branch_comp_seq
  import branch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            BrEq,
  output logic            BrLT,
  output logic            taken,
  output logic            illegal
);

  localparam int unsigned NCHUNK = XLEN / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [XLEN-1:0] MsbMask = {1'b1, {(XLEN-1){1'b0}}};

  brState            state;
  logic [XLEN-1:0]   aLat;
  logic [XLEN-1:0]   bLat;
  logic [2:0]        f3Lat;
  logic [IdxW-1:0]   chunkIdx;
  logic              decided;
  logic              ltAcc;

  logic [CHUNK-1:0]  sliceA;
  logic [CHUNK-1:0]  sliceB;
  logic              sliceEq;
  logic              sliceLt;
  logic              signedCmp;
  logic              decNext;
  logic              ltNext;
  logic              exitNow;

  assign in_ready  = (state == StIdle);
  // Flipping the sign bits turns a signed compare into an unsigned one.
  assign signedCmp = (funct3[2:1] != 2'b11);

  assign sliceA = aLat[chunkIdx*CHUNK +: CHUNK];
  assign sliceB = bLat[chunkIdx*CHUNK +: CHUNK];

  chunk_comp #(
    .CHUNK(CHUNK)
  ) u_chunk_comp (
    .a (sliceA),
    .b (sliceB),
    .eq(sliceEq),
    .lt(sliceLt)
  );

  // Accumulated result after this cycle's slice; the first differing slice wins.
  always_comb begin
    decNext = decided | !sliceEq;
    ltNext  = decided ? ltAcc : (!sliceEq & sliceLt);
`ifdef BRCOMP_EARLY_EXIT_EN
    exitNow = (chunkIdx == '0) || (!decided && !sliceEq);
`else
    exitNow = (chunkIdx == '0);
`endif
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      aLat      <= '0;
      bLat      <= '0;
      f3Lat     <= '0;
      chunkIdx  <= '0;
      decided   <= 1'b0;
      ltAcc     <= 1'b0;
      out_valid <= 1'b0;
      BrEq      <= 1'b0;
      BrLT      <= 1'b0;
      taken     <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      state     <= StIdle;
      chunkIdx  <= '0;
      decided   <= 1'b0;
      ltAcc     <= 1'b0;
      out_valid <= 1'b0;
      BrEq      <= 1'b0;
      BrLT      <= 1'b0;
      taken     <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            aLat     <= signedCmp ? (dataA ^ MsbMask) : dataA;
            bLat     <= signedCmp ? (dataB ^ MsbMask) : dataB;
            f3Lat    <= funct3;
            chunkIdx <= IdxW'(NCHUNK - 1);
            decided  <= 1'b0;
            ltAcc    <= 1'b0;
            state    <= isIllegal(funct3) ? StDone : StCmp;
          end
        end
        StCmp: begin
          decided <= decNext;
          ltAcc   <= ltNext;
          if (exitNow) begin
            state     <= StDone;
            out_valid <= 1'b1;
            BrEq      <= !decNext;
            BrLT      <= decNext & ltNext;
            taken     <= takenOf(f3Lat, !decNext, decNext & ltNext);
          end else begin
            chunkIdx <= chunkIdx - IdxW'(1);
          end
        end
        StDone: begin
          if (!out_valid) begin
            // Only illegal requests arrive here without a result; present it one edge later.
            out_valid <= 1'b1;
            illegal   <= 1'b1;
          end else if (out_ready) begin
            state     <= StIdle;
            chunkIdx  <= '0;
            decided   <= 1'b0;
            ltAcc     <= 1'b0;
            out_valid <= 1'b0;
            BrEq      <= 1'b0;
            BrLT      <= 1'b0;
            taken     <= 1'b0;
            illegal   <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_comp_seq.sv
// Directed self-checking bench for branch_comp_seq (XLEN 32, CHUNK 4).
module tb_branch_comp_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        BrEq;
  logic        BrLT;
  logic        taken;
  logic        illegal;

  int nChecks = 0;
  int nPassed = 0;

`ifdef BRCOMP_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  branch_comp_seq #(
    .XLEN (32),
    .CHUNK(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .funct3   (funct3),
    .dataA    (dataA),
    .dataB    (dataB),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .BrEq     (BrEq),
    .BrLT     (BrLT),
    .taken    (taken),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPassed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected compare latency when the first differing slice is the m-th from the MSB.
  function automatic int latOf(input int m);
    return Early ? m : 8;
  endfunction

  task automatic accept(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("readyBeforeAccept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    funct3   = f3;
    dataA    = a;
    dataB    = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // flags = {BrEq, BrLT, taken, illegal}
  task automatic runReq(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int expLat, input logic [3:0] expFlags);
    int lat;
    accept(f3, a, b);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!out_valid && lat < 40);
    check({tag, ".lat"}, lat, expLat);
    check({tag, ".flags"}, {28'd0, BrEq, BrLT, taken, illegal}, {28'd0, expFlags});
    if (out_ready) begin
      @(posedge clk);
      #1 check({tag, ".back"}, {26'd0, in_ready, out_valid, BrEq, BrLT, taken, illegal},
               32'b100000);
    end
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    funct3    = 3'b000;
    dataA     = '0;
    dataB     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset", {26'd0, in_ready, out_valid, BrEq, BrLT, taken, illegal}, 32'b100000);
    rst_n = 1'b1;

    runReq("beqEqual", 3'b000, 32'h12345678, 32'h12345678, 8, 4'b1010);
    runReq("bltNeg",   3'b100, 32'hFFFFFFFF, 32'h00000001, latOf(1), 4'b0110);
    runReq("bltuNeg",  3'b110, 32'hFFFFFFFF, 32'h00000001, latOf(1), 4'b0000);
    runReq("bgeuMsb",  3'b111, 32'h80000000, 32'h7FFFFFFF, latOf(1), 4'b0010);
    runReq("illegal",  3'b010, 32'h00000001, 32'h00000002, 1,        4'b0001);
    runReq("illegal3", 3'b011, 32'h00000005, 32'h00000005, 1,        4'b0001);
    runReq("bneLast",  3'b001, 32'h00000005, 32'h00000003, latOf(8), 4'b0010);
    runReq("bgeMid",   3'b101, 32'h00100000, 32'h00200000, latOf(3), 4'b0100);
    // Later slices would say A<B; the decided slice must keep A>B.
    runReq("bltLock",  3'b100, 32'h00200000, 32'h001FFFFF, latOf(3), 4'b0000);
    runReq("bgeEqual", 3'b101, 32'h80000000, 32'h80000000, 8,        4'b1010);

    // Consumer stalls for 5 cycles.
    out_ready = 1'b0;
    runReq("stall", 3'b000, 32'h12345678, 32'h12345678, 8, 4'b1010);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("stallHold", {26'd0, in_ready, out_valid, BrEq, BrLT, taken, illegal},
               32'b011010);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("stallRelease", {26'd0, in_ready, out_valid, BrEq, BrLT, taken, illegal},
             32'b100000);

    // Flush on the edge ending CMP cycle 3.
    accept(3'b000, 32'hCAFEF00D, 32'hCAFEF00D);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flushIdle", {30'd0, in_ready, out_valid}, 32'b10);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    check("flushNoValid", seen, 0);
    runReq("afterFlush", 3'b100, 32'hFFFFFFFF, 32'h00000001, latOf(1), 4'b0110);

    // Flush wins over a simultaneous accept.
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    funct3   = 3'b000;
    dataA    = 32'h1;
    dataB    = 32'h1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (out_valid || !in_ready) seen++;
    end
    check("flushOverAccept", seen, 0);

    // Asynchronous reset during CMP cycle 2.
    accept(3'b000, 32'h0F0F0F0F, 32'h0F0F0F0F);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rstMidCmp", {26'd0, in_ready, out_valid, BrEq, BrLT, taken, illegal},
             32'b100000);
    @(negedge clk);
    rst_n = 1'b1;
    runReq("afterReset", 3'b111, 32'h80000000, 32'h7FFFFFFF, latOf(1), 4'b0010);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
